// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between instruction fetch and decode.
// Holds {pc, inst, predict} packets, flushes every queued packet in one cycle
// on a redirect, and presents a NOP bubble to decode whenever it is empty.
module fetch_queue #(
   parameter int          DEPTH = 4,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_inst,
   input  logic                     in_predict,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   output logic                     out_predict,
   input  logic                     id_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Packet storage; never reset, stale entries are masked by the occupancy.
   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] inst_mem [DEPTH];
   logic        pred_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] occ;

   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [CNT_W-1:0] occ_next;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Status flags come only from registered occupancy, so in_ready has no
   // combinational path from id_ready: a full queue refuses a push even when
   // decode drains an entry in the same cycle.
   always_comb begin
      full      = (occ == FULL_CNT);
      empty     = (occ == '0);
      in_ready  = !full;
      out_valid = !empty;
      push      = in_valid && !full && !flush;
      pop       = !empty && id_ready && !flush;
   end

   // Next pointer/occupancy: flush wins over everything, otherwise the
   // pointers advance independently and occupancy nets push against pop.
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      occ_next    = occ;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         occ_next    = '0;
      end else begin
         if (push) wr_ptr_next = wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr_next = rd_ptr + PTR_W'(1);
         if (push && !pop)      occ_next = occ + CNT_W'(1);
         else if (pop && !push) occ_next = occ - CNT_W'(1);
      end
   end

   // Control state; reset acts immediately so decode sees a bubble at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         occ    <= occ_next;
      end
   end

   // Write the accepted packet into the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= in_pc;
         inst_mem[wr_ptr] <= in_inst;
         pred_mem[wr_ptr] <= in_predict;
      end
   end

   // Head is read combinationally; an empty queue shows a NOP bubble.
   always_comb begin
      if (empty) begin
         out_pc      = '0;
         out_inst    = NOP;
         out_predict = 1'b0;
      end else begin
         out_pc      = pc_mem[rd_ptr];
         out_inst    = inst_mem[rd_ptr];
         out_predict = pred_mem[rd_ptr];
      end
   end

   assign count = occ;

`ifndef SYNTHESIS
   // Occupancy stays bounded and agrees with the pointer relationship.
   always @(posedge clk) begin
      if (!rst) begin
         assert (occ <= FULL_CNT);
         if (occ != FULL_CNT) assert ((occ == '0) == (wr_ptr == rd_ptr));
         else                 assert (wr_ptr == rd_ptr);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based model
// of the fetch queue (arrival-order packets, bubble when empty).
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_predict;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_predict;
   logic        id_ready;
   logic [2:0]  count;

   fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_predict(in_predict),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_predict(out_predict),
      .id_ready(id_ready), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } pkt_t;

   pkt_t model_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's view of the queue.
   task automatic check_all(input string tag);
      int n;
      n = model_q.size();
      chk({tag, " count"},    32'(count),     32'(n));
      chk({tag, " in_ready"}, 32'(in_ready),  32'(n < DEPTH));
      chk({tag, " out_valid"},32'(out_valid), 32'(n > 0));
      if (n > 0) begin
         chk({tag, " out_pc"},   out_pc,            model_q[0].pc);
         chk({tag, " out_inst"}, out_inst,          model_q[0].inst);
         chk({tag, " out_pred"}, 32'(out_predict),  32'(model_q[0].pred));
      end else begin
         chk({tag, " out_pc"},   out_pc,            32'h0);
         chk({tag, " out_inst"}, out_inst,          NOP);
         chk({tag, " out_pred"}, 32'(out_predict),  32'h0);
      end
   endtask

   // One clock cycle: drive inputs, confirm outputs ignore them (no bypass),
   // advance the model with the same inputs, then check the new state.
   task automatic step(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic pred,
                       input logic rdy, input logic fl);
      logic do_push, do_pop;
      pkt_t p;
      in_valid = v; in_pc = pc; in_inst = inst; in_predict = pred;
      id_ready = rdy; flush = fl;
      #1;
      check_all({tag, " pre"});
      do_push = v && (model_q.size() < DEPTH) && !fl;
      do_pop  = (model_q.size() > 0) && rdy && !fl;
      @(posedge clk);
      if (fl) model_q.delete();
      else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            p.pc = pc; p.inst = inst; p.pred = pred;
            model_q.push_back(p);
         end
      end
      #1;
      check_all(tag);
      $display("%s: v=%0b pc=%h rdy=%0b fl=%0b -> count=%0d out_valid=%0b out_pc=%h",
               tag, v, pc, rdy, fl, count, out_valid, out_pc);
   endtask

   initial begin
      rst = 1'b1; flush = 0; in_valid = 0; in_pc = 0; in_inst = 0;
      in_predict = 0; id_ready = 0;
      #1;
      check_all("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_all("idle");

      // Fill with decode stalled, then the held fifth packet.
      for (int i = 0; i < 4; i++)
         step("fill", 1, 32'(i * 4), 32'h1000_0000 + 32'(i), i[0], 0, 0);
      chk("fill out_pc", out_pc, 32'h0);
      chk("fill in_ready", 32'(in_ready), 32'h0);
      step("hold", 1, 32'h10, 32'hAAAA_0010, 1, 0, 0);
      step("fullpop", 1, 32'h10, 32'hAAAA_0010, 1, 1, 0);
      chk("fullpop count", 32'(count), 32'd3);
      step("accept", 1, 32'h10, 32'hAAAA_0010, 1, 0, 0);
      for (int i = 0; i < 5; i++)
         step("drain", 0, 32'h0, 32'h0, 0, 1, 0);

      // Streaming: simultaneous push and pop keep one entry in flight.
      for (int i = 0; i < 8; i++)
         step("stream", 1, 32'h100 + 32'(i * 4), 32'h2000_0000 + 32'(i), 0, 1, 0);
      chk("stream count", 32'(count), 32'd1);
      step("drain", 0, 32'h0, 32'h0, 0, 1, 0);

      // Flush with a simultaneous push of 0x40.
      for (int i = 0; i < 3; i++)
         step("pre_flush", 1, 32'h20 + 32'(i * 4), 32'h3000_0000 + 32'(i), 1, 0, 0);
      step("flush", 1, 32'h40, 32'h4000_0040, 1, 1, 1);
      chk("flush count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++)
         step("post_flush", 0, 32'h0, 32'h0, 0, 1, 0);

      // Random traffic across many pointer wraps.
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), $urandom() & 32'hFFFF_FFFC,
              $urandom(), 1'($urandom()), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 29) == 0));

      // Asynchronous reset mid-stream with three entries queued.
      step("pre_rst", 0, 32'h0, 32'h0, 0, 1, 1);
      for (int i = 0; i < 3; i++)
         step("pre_rst", 1, 32'h80 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1, 0, 0);
      in_valid = 1; in_pc = 32'h8C; id_ready = 0;
      #2;
      rst = 1'b1;
      model_q.delete();
      #1;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      in_valid = 0;
      @(posedge clk); #1;
      check_all("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
